// File: rtl/mips_decode_stage_pkg.sv
// mips_defs: opcode/funct constants, decode-stage FSM encoding and decoded-field bundle
//   shared by mips_decoder and mips_decode_stage; no ports
package mips_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_BUBBLE} state_t;
  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
  } dec_t;
  function automatic logic reads_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/mips_decode_stage_if.sv
// mips_decode_stage_if: fetch->decode, decode->regfile and decode->execute signal bundle
//   master: fetch/execute side (drives if_valid/if_instr/if_pc/ex_ready)
//   slave : decode stage (drives if_ready, rf_addr_a/b and the id_* bundle)
interface mips_decode_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [4:0]  rf_addr_a;
  logic [4:0]  rf_addr_b;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [4:0]  id_dest;
  logic [31:0] id_imm;
  logic        id_reg_we;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_jump;
  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, rf_addr_a, rf_addr_b, id_valid, id_pc, id_opcode, id_funct, id_shamt,
           id_dest, id_imm, id_reg_we, id_mem_read, id_mem_write, id_branch, id_jump
  );
  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, rf_addr_a, rf_addr_b, id_valid, id_pc, id_opcode, id_funct, id_shamt,
           id_dest, id_imm, id_reg_we, id_mem_read, id_mem_write, id_branch, id_jump
  );
endinterface

// File: rtl/mips_decode_stage_decoder.sv
// mips_decoder: combinational field decode and immediate generation
//   i_instr  : instruction word
//   i_pc_hi  : pc[31:28] of that instruction, for jump targets
//   o_dec    : decoded fields and control flags
//   o_uses_rt: instruction reads rt as a source register
module mips_decoder
  import mips_defs::*;
(
  input  logic [31:0] i_instr,
  input  logic [3:0]  i_pc_hi,
  output dec_t        o_dec,
  output logic        o_uses_rt
);
  logic [5:0]  w_op;
  logic [15:0] w_imm16;
  logic        w_rtype;
  logic        w_jr;
  logic        w_itype;
  logic        w_jal;
  logic [4:0]  w_dest;
  assign w_op    = i_instr[31:26];
  assign w_imm16 = i_instr[15:0];
  assign w_rtype = w_op == OP_RTYPE;
  assign w_jr    = w_rtype && i_instr[5:0] == FN_JR;
  // 0x08-0x0F is the immediate-ALU group; LW also writes rt
  assign w_itype = w_op[5:3] == 3'b001 || w_op == OP_LW;
  assign w_jal   = w_op == OP_JAL;
  assign w_dest  = w_rtype ? i_instr[15:11] : w_itype ? i_instr[20:16] : w_jal ? 5'd31 : 5'd0;
  assign o_uses_rt = reads_rt(w_op);
  always_comb begin
    o_dec           = '0;
    o_dec.opcode    = w_op;
    o_dec.funct     = i_instr[5:0];
    o_dec.shamt     = i_instr[10:6];
    o_dec.rs        = i_instr[25:21];
    o_dec.rt        = i_instr[20:16];
    o_dec.dest      = w_dest;
    o_dec.imm       = (w_op == OP_ANDI || w_op == OP_ORI || w_op == OP_XORI) ? {16'h0, w_imm16} :
                      w_op == OP_LUI ? {w_imm16, 16'h0} :
                      (w_op == OP_J || w_jal) ? {i_pc_hi, i_instr[25:0], 2'b00} :
                      {{16{w_imm16[15]}}, w_imm16};
    o_dec.reg_we    = ((w_rtype && !w_jr) || w_itype || w_jal) && w_dest != 5'd0;
    o_dec.mem_read  = w_op == OP_LW;
    o_dec.mem_write = w_op == OP_SW;
    o_dec.branch    = w_op == OP_BEQ || w_op == OP_BNE;
    o_dec.jump      = w_jr || w_op == OP_J || w_jal;
  end
endmodule

// File: rtl/mips_decode_stage.sv
// mips_decode_stage: MIPS decode pipeline stage with valid/ready handshakes and load-use stall
//   clk, reset: clock and asynchronous active-high reset
//   bus (slave): if_valid/if_instr/if_pc/if_ready from fetch, rf_addr_a/b to the register file,
//                ex_ready and the id_* bundle to execute
module mips_decode_stage
  import mips_defs::*;
(
  input logic                clk,
  input logic                reset,
  mips_decode_stage_if.slave bus
);
  state_t      r_state;
  dec_t        r_dec;
  logic [31:0] r_pc;
  dec_t        w_dec;
  logic        w_uses_rt;
  logic        w_leave;
  logic        w_hazard;
  logic        w_ready;
  logic        w_accept;
  mips_decoder u_dec (
    .i_instr  (bus.if_instr),
    .i_pc_hi  (bus.if_pc[31:28]),
    .o_dec    (w_dec),
    .o_uses_rt(w_uses_rt)
  );
  assign w_leave  = r_state == S_FULL && bus.ex_ready;
  // a departing LW leaves its result a cycle short of the reader, so hold the reader back one slot
  assign w_hazard = w_leave && r_dec.mem_read && r_dec.dest != 5'd0 && bus.if_valid &&
                    (w_dec.rs == r_dec.dest || (w_uses_rt && w_dec.rt == r_dec.dest));
  assign w_ready  = r_state != S_FULL || (bus.ex_ready && !w_hazard);
  assign w_accept = bus.if_valid && w_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_dec   <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_accept ? S_FULL : w_hazard ? S_BUBBLE :
                 (r_state == S_FULL && !bus.ex_ready) ? S_FULL : S_EMPTY;
      if (w_accept) begin
        r_dec <= w_dec;
        r_pc  <= bus.if_pc;
      end
    end
  end
  assign bus.if_ready     = w_ready;
  // the register file answers one cycle later, so address whatever will be held next cycle
  assign bus.rf_addr_a    = w_accept ? w_dec.rs : r_dec.rs;
  assign bus.rf_addr_b    = w_accept ? w_dec.rt : r_dec.rt;
  assign bus.id_valid     = r_state == S_FULL;
  assign bus.id_pc        = r_pc;
  assign bus.id_opcode    = r_dec.opcode;
  assign bus.id_funct     = r_dec.funct;
  assign bus.id_shamt     = r_dec.shamt;
  assign bus.id_dest      = r_dec.dest;
  assign bus.id_imm       = r_dec.imm;
  assign bus.id_reg_we    = r_dec.reg_we;
  assign bus.id_mem_read  = r_dec.mem_read;
  assign bus.id_mem_write = r_dec.mem_write;
  assign bus.id_branch    = r_dec.branch;
  assign bus.id_jump      = r_dec.jump;
endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage: directed and random checks of mips_decode_stage against a behavioural model
module tb_mips_decode_stage;
  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        we, mr, mw, br, jp;
  } ref_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_held;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [5:0]  ops [14] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                            6'h0C, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h3F};
  mips_decode_stage_if bus ();
  mips_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic ref_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    ref_t r;
    logic [31:0] op, rt, rd, imm16;
    op    = ins >> 26;
    rt    = (ins >> 16) & 32'd31;
    rd    = (ins >> 11) & 32'd31;
    imm16 = ins & 32'hFFFF;
    r = '{default: '0};
    r.opcode = 6'(op);
    r.funct  = 6'(ins & 32'd63);
    r.shamt  = 5'((ins >> 6) & 32'd31);
    if (op >= 32'd12 && op <= 32'd14) r.imm = imm16;
    else if (op == 32'd15) r.imm = imm16 * 32'd65536;
    else if (op == 32'd2 || op == 32'd3) r.imm = (pc & 32'hF0000000) + (ins & 32'h03FFFFFF) * 32'd4;
    else r.imm = imm16 >= 32'd32768 ? imm16 - 32'd65536 : imm16;
    if (op == 32'd0) begin
      r.dest = 5'(rd);
      r.jp   = (ins & 32'd63) == 32'd8;
      r.we   = !r.jp;
    end else if ((op >= 32'd8 && op <= 32'd15) || op == 32'd35) begin
      r.dest = 5'(rt);
      r.we   = 1'b1;
      r.mr   = op == 32'd35;
    end else if (op == 32'd43) r.mw = 1'b1;
    else if (op == 32'd4 || op == 32'd5) r.br = 1'b1;
    else if (op == 32'd2) r.jp = 1'b1;
    else if (op == 32'd3) begin
      r.jp   = 1'b1;
      r.we   = 1'b1;
      r.dest = 5'd31;
    end
    if (r.dest == 5'd0) r.we = 1'b0;
    return r;
  endfunction
  function automatic logic load_use(input logic [31:0] held, input logic v, input logic [31:0] ins);
    logic [31:0] op, d;
    op = ins >> 26;
    d  = (held >> 16) & 32'd31;
    if (!v || (held >> 26) != 32'd35 || d == 32'd0) return 1'b0;
    return ((ins >> 21) & 32'd31) == d ||
           ((op == 32'd0 || op == 32'd43 || op == 32'd4 || op == 32'd5) && ((ins >> 16) & 32'd31) == d);
  endfunction
  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [5:0]  op;
    op = ops[$urandom_range(0, 13)];
    r  = $urandom;
    r[31:26] = op;
    r[25:21] = 5'($urandom_range(0, 3));
    r[20:16] = 5'($urandom_range(0, 3));
    if (op == 6'h00) r[5:0] = $urandom_range(0, 3) == 0 ? 6'h08 : 6'h20;
    return r;
  endfunction
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic er,
                      output logic acc);
    logic exp_rdy;
    ref_t r;
    @(negedge clk);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.ex_ready = er;
    #1;
    exp_rdy = !m_held || (er && !load_use(m_instr, v, ins));
    acc     = v && exp_rdy;
    chk("id_valid", bus.id_valid, m_held);
    chk("if_ready", bus.if_ready, exp_rdy);
    chk("rf_addr_a", bus.rf_addr_a, acc ? ins[25:21] : m_instr[25:21]);
    chk("rf_addr_b", bus.rf_addr_b, acc ? ins[20:16] : m_instr[20:16]);
    if (m_held) begin
      r = ref_dec(m_instr, m_pc);
      chk("id_pc", bus.id_pc, m_pc);
      chk("id_opcode", bus.id_opcode, r.opcode);
      chk("id_funct", bus.id_funct, r.funct);
      chk("id_shamt", bus.id_shamt, r.shamt);
      chk("id_dest", bus.id_dest, r.dest);
      chk("id_imm", bus.id_imm, r.imm);
      chk("id_flags", {bus.id_reg_we, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump},
          {r.we, r.mr, r.mw, r.br, r.jp});
    end
    if (m_held && er) m_held = 1'b0;
    if (acc) begin
      m_held  = 1'b1;
      m_instr = ins;
      m_pc    = pc;
    end
  endtask
  initial begin
    logic        acc, c_v;
    logic [31:0] c_ins, c_pc;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.ex_ready = 1'b0;
    m_held = 1'b0;
    m_instr = '0;
    m_pc = '0;
    acc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.id_valid, 1'b0);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_imm", bus.id_imm, 32'h0);
    chk("rst_dest", bus.id_dest, 5'd0);
    chk("rst_flags", {bus.id_reg_we, bus.id_mem_read, bus.id_mem_write, bus.id_branch, bus.id_jump}, 5'd0);
    reset = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b1, acc);
    step(1'b1, 32'h00221820, 32'h100, 1'b1, acc);
    chk("add_rf_a", bus.rf_addr_a, 5'd1);
    chk("add_rf_b", bus.rf_addr_b, 5'd2);
    repeat (3) begin
      step(1'b1, 32'h2002FFFF, 32'h104, 1'b0, acc);
      chk("stall_ready", bus.if_ready, 1'b0);
      chk("stall_pc", bus.id_pc, 32'h100);
      chk("stall_dest", bus.id_dest, 5'd3);
      chk("stall_we", bus.id_reg_we, 1'b1);
      chk("stall_rf_a", bus.rf_addr_a, 5'd1);
    end
    step(1'b1, 32'h2002FFFF, 32'h104, 1'b1, acc);
    step(1'b1, 32'h3402FFFF, 32'h108, 1'b1, acc);
    chk("addi_imm", bus.id_imm, 32'hFFFFFFFF);
    step(1'b1, 32'h3C011234, 32'h10C, 1'b1, acc);
    chk("ori_imm", bus.id_imm, 32'h0000FFFF);
    step(1'b1, 32'h0C100000, 32'h00400000, 1'b1, acc);
    chk("lui_imm", bus.id_imm, 32'h12340000);
    step(1'b1, 32'h8C050004, 32'h110, 1'b1, acc);
    chk("jal_jump", bus.id_jump, 1'b1);
    chk("jal_dest", bus.id_dest, 5'd31);
    chk("jal_imm", bus.id_imm, 32'h00400000);
    step(1'b1, 32'h00A13020, 32'h114, 1'b1, acc);
    chk("lu_ready", bus.if_ready, 1'b0);
    step(1'b1, 32'h00A13020, 32'h114, 1'b1, acc);
    chk("bubble_valid", bus.id_valid, 1'b0);
    chk("bubble_ready", bus.if_ready, 1'b1);
    step(1'b1, 32'h2002FFFF, 32'h118, 1'b0, acc);
    chk("post_bubble_pc", bus.id_pc, 32'h114);
    chk("post_bubble_dest", bus.id_dest, 5'd6);
    #2;
    reset = 1'b1;
    bus.if_valid = 1'b0;
    #1;
    chk("async_rst_valid", bus.id_valid, 1'b0);
    chk("async_rst_pc", bus.id_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    m_held = 1'b0;
    m_instr = '0;
    m_pc = '0;
    step(1'b0, 32'h0, 32'h0, 1'b1, acc);
    c_v = 1'b0;
    c_ins = '0;
    c_pc = 32'h1000;
    acc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_v || acc) begin
        c_v   = $urandom_range(0, 3) != 0;
        c_ins = rand_ins();
        c_pc  = c_pc + 32'd4;
      end
      step(c_v, c_ins, c_pc, $urandom_range(0, 2) != 0, acc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
